combo_lock_fsm: RTL and testbench
=================================

Name: combo_lock_fsm

Overview:
Parametrised master FSM for the safe's combination lock.
- Generalises the fixed three-number sequence to DIGITS numbers.
- Adds a failed-attempt counter with a timed lockout and alarm output.
- Sits between the dial counter/comparator (cnten, up, dirch, eq) and the lock actuator/display (sel, blank, actuateLock, openCls).

Parameters:
- DIGITS, 3, number of combination numbers; range 2 to 2**SEL_W.
- SEL_W, 2, width of sel (digit index driven to the code mux).
- MAX_FAIL, 3, consecutive bad attempts that trigger lockout; range 1 to 2**FAIL_W-1.
- FAIL_W, 2, width of the fail counter.
- LOCKOUT_CYC, 1000, clock cycles spent in LOCKOUT.
- CNT_W, 16, width of the lockout/relock timer; must hold LOCKOUT_CYC and RELOCK_CYC.
- RELOCK_CYC, 500, door-closed cycles before auto relock (used only with AUTO_RELOCK_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cnten  in  1  dial counter enable status; 0 together with up=0 starts entry
- up  in  1  dial direction
- dirch  in  1  single-cycle pulse on dial direction change
- doorCls  in  1  door closed, active-low
- lock  in  1  lock button, active-low
- open  in  1  open button, active-low
- eq  in  1  dial value equals the currently selected code number
- countEn  out  1  dial counter enable
- actuateLock  out  1  lock actuator drive
- openCls  out  1  bolt open pulse
- sel  out  SEL_W  code digit index
- blank  out  1  display blank
- clrCount  out  1  dial counter clear control; 0 = clear
- alarm  out  1  lockout in progress
- fail_cnt  out  FAIL_W  consecutive failed attempts

Behaviour:
- State register and all outputs use the same asynchronous active-high reset.
- States: LOCKED, START, DIGIT, OPEN_P, UNLOCKED, LOCK_P, BAD, LOCKOUT. Internal index idx has SEL_W bits.
- All outputs except fail_cnt are registered decodes of the current state. They change one cycle after the state is entered.
- Reset values: state LOCKED, idx 0, blank 1, countEn 1, clrCount 0, sel 0, actuateLock 0, openCls 0, alarm 0, fail_cnt 0, timer 0.
- LOCKED: open==0 -> START; otherwise stay.
- START: cnten==0 && up==0 -> DIGIT with idx=0; otherwise stay.
- DIGIT, idx<DIGITS-1:
  - dirch && eq -> idx+1, stay in DIGIT.
  - dirch && !eq -> BAD.
  - otherwise hold. open is ignored.
- DIGIT, idx==DIGITS-1:
  - open==0 && eq -> OPEN_P.
  - open==0 && !eq -> BAD.
  - dirch && !eq -> BAD.
  - otherwise hold.
  - open takes priority over dirch in the same cycle.
- OPEN_P: one cycle -> UNLOCKED; fail_cnt cleared to 0.
- UNLOCKED: lock==0 && doorCls==0 -> LOCK_P; lock pressed with door open is ignored.
- LOCK_P: one cycle -> LOCKED.
- BAD: one cycle; fail_cnt increments, saturating at MAX_FAIL.
  - If the new value == MAX_FAIL -> LOCKOUT, timer loaded with LOCKOUT_CYC-1.
  - Otherwise -> LOCKED.
- LOCKOUT: timer decrements each cycle; all inputs ignored. At timer==0 -> LOCKED and fail_cnt cleared. LOCKOUT lasts exactly LOCKOUT_CYC cycles.
- idx resets to 0 on every entry to LOCKED.
- Output decode by state:
  - blank = 1 in LOCKED, UNLOCKED, LOCKOUT; 0 elsewhere.
  - countEn = 1 only in LOCKED.
  - clrCount = 0 in LOCKED, UNLOCKED, LOCKOUT; 1 elsewhere.
  - sel = idx in DIGIT; 0 elsewhere.
  - openCls = 1 only in OPEN_P.
  - actuateLock = 1 in OPEN_P; = !doorCls in LOCK_P; 0 elsewhere.
  - alarm = 1 in LOCKOUT.
- fail_cnt is driven directly from its register.
- Reset asserted mid-sequence or mid-lockout returns everything to reset values immediately. A lockout does not survive reset.

Optional Feature:
AUTO_RELOCK_EN
- Defined:
  - In UNLOCKED, the timer counts consecutive cycles with doorCls==0 and lock==1.
  - Any cycle with doorCls==1 reloads the count to 0.
  - Reaching RELOCK_CYC -> LOCK_P.
  - A lock press still relocks immediately and takes priority.
- Undefined: UNLOCKED exits only via lock; the timer is used for lockout only.

Test Plan:
- Reset, then open=0 for 1 cycle -> START; cnten=0, up=0 -> DIGIT with sel=0 one cycle later, blank=0, clrCount=1.
- DIGITS=3: dirch&&eq twice, then open=0&&eq -> sel steps 0,1,2; openCls=1 and actuateLock=1 for exactly 1 cycle; then blank=1; fail_cnt=0.
- In UNLOCKED: lock=0 with doorCls=1 -> stays UNLOCKED. Then lock=0, doorCls=0 -> actuateLock=1 for 1 cycle, then LOCKED, countEn=1.
- MAX_FAIL=3, LOCKOUT_CYC=20: three dirch&&!eq failures -> fail_cnt 1,2,3. alarm=1 for 20 cycles; open pulses ignored during lockout; then fail_cnt=0, alarm=0.
- Last digit with open=0 and dirch=1 in the same cycle, eq=1 -> OPEN_P, not BAD. Assert rst during LOCKOUT -> alarm=0 and all outputs at reset values in the same cycle.
- AUTO_RELOCK_EN, RELOCK_CYC=8: door closed 5 cycles, open 1 cycle, closed 8 cycles -> relock 8 cycles after the reopen, not earlier.

Source files
------------

// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - combination lock master FSM with fail counter, timed lockout and alarm
// Define AUTO_RELOCK_EN to relock automatically after RELOCK_CYC door-closed cycles in UNLOCKED.
module combo_lock_fsm #(
    parameter int DIGITS      = 3,
    parameter int SEL_W       = 2,
    parameter int MAX_FAIL    = 3,
    parameter int FAIL_W      = 2,
    parameter int LOCKOUT_CYC = 1000,
    parameter int CNT_W       = 16,
    parameter int RELOCK_CYC  = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnten,
    input  logic              up,
    input  logic              dirch,
    input  logic              doorCls,
    input  logic              lock,
    input  logic              open,
    input  logic              eq,
    output logic              countEn,
    output logic              actuateLock,
    output logic              openCls,
    output logic [SEL_W-1:0]  sel,
    output logic              blank,
    output logic              clrCount,
    output logic              alarm,
    output logic [FAIL_W-1:0] fail_cnt
);

    localparam logic [2:0] S_LOCKED   = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DIGIT    = 3'd2;
    localparam logic [2:0] S_OPEN_P   = 3'd3;
    localparam logic [2:0] S_UNLOCKED = 3'd4;
    localparam logic [2:0] S_LOCK_P   = 3'd5;
    localparam logic [2:0] S_BAD      = 3'd6;
    localparam logic [2:0] S_LOCKOUT  = 3'd7;

    localparam logic [SEL_W-1:0]  LAST_IDX     = SEL_W'(DIGITS - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAIL);
    localparam logic [CNT_W-1:0]  LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  RELOCK_LAST  = CNT_W'(RELOCK_CYC - 1);

    if (DIGITS < 2 || DIGITS > (1 << SEL_W)) begin : g_bad_digits
        $error("combo_lock_fsm: DIGITS out of range for SEL_W");
    end
    if (MAX_FAIL < 1 || MAX_FAIL > (1 << FAIL_W) - 1) begin : g_bad_max_fail
        $error("combo_lock_fsm: MAX_FAIL out of range for FAIL_W");
    end
    if (LOCKOUT_CYC < 1 || LOCKOUT_CYC > (1 << CNT_W)) begin : g_bad_lockout
        $error("combo_lock_fsm: LOCKOUT_CYC does not fit CNT_W");
    end
    if (RELOCK_CYC < 1 || RELOCK_CYC > (1 << CNT_W)) begin : g_bad_relock
        $error("combo_lock_fsm: RELOCK_CYC does not fit CNT_W");
    end

    logic [2:0]        state;
    logic [SEL_W-1:0]  idx;
    logic [CNT_W-1:0]  timer;
    logic [FAIL_W-1:0] fail_q;
    logic [FAIL_W-1:0] fail_inc;

    assign fail_inc = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + FAIL_W'(1);
    assign fail_cnt = fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_LOCKED;
            idx    <= '0;
            timer  <= '0;
            fail_q <= '0;
        end else begin
            case (state)
                S_LOCKED: begin
                    idx <= '0;
                    if (!open) state <= S_START;
                end
                S_START: begin
                    if (!cnten && !up) begin
                        idx   <= '0;
                        state <= S_DIGIT;
                    end
                end
                S_DIGIT: begin
                    // On the last number the open button is checked before any dial reversal.
                    if (idx == LAST_IDX) begin
                        if (!open)              state <= eq ? S_OPEN_P : S_BAD;
                        else if (dirch && !eq)  state <= S_BAD;
                    end else if (dirch) begin
                        if (eq) idx   <= idx + SEL_W'(1);
                        else    state <= S_BAD;
                    end
                end
                S_OPEN_P: begin
                    state  <= S_UNLOCKED;
                    fail_q <= '0;
                    timer  <= '0;
                end
                S_UNLOCKED: begin
`ifdef AUTO_RELOCK_EN
                    if (!lock && !doorCls) begin
                        state <= S_LOCK_P;
                        timer <= '0;
                    end else if (doorCls) begin
                        timer <= '0;
                    end else if (timer == RELOCK_LAST) begin
                        state <= S_LOCK_P;
                        timer <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
`else
                    if (!lock && !doorCls) state <= S_LOCK_P;
`endif
                end
                S_LOCK_P: begin
                    state <= S_LOCKED;
                    idx   <= '0;
                end
                S_BAD: begin
                    fail_q <= fail_inc;
                    idx    <= '0;
                    if (fail_inc == FAIL_LIMIT) begin
                        state <= S_LOCKOUT;
                        timer <= LOCKOUT_LOAD;
                    end else begin
                        state <= S_LOCKED;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state  <= S_LOCKED;
                        fail_q <= '0;
                        idx    <= '0;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_LOCKED;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Outputs are registered decodes of the current state, so they lag state entry by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank       <= 1'b1;
            countEn     <= 1'b1;
            clrCount    <= 1'b0;
            sel         <= '0;
            actuateLock <= 1'b0;
            openCls     <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            blank       <= (state == S_LOCKED) || (state == S_UNLOCKED) || (state == S_LOCKOUT);
            countEn     <= (state == S_LOCKED);
            clrCount    <= !((state == S_LOCKED) || (state == S_UNLOCKED) || (state == S_LOCKOUT));
            sel         <= (state == S_DIGIT) ? idx : '0;
            actuateLock <= (state == S_OPEN_P) || ((state == S_LOCK_P) && !doorCls);
            openCls     <= (state == S_OPEN_P);
            alarm       <= (state == S_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - scoreboard bench for combo_lock_fsm (DIGITS=3, MAX_FAIL=3, LOCKOUT_CYC=20)
module tb_combo_lock_fsm;

    localparam int T_LOCKED   = 0;
    localparam int T_START    = 1;
    localparam int T_DIGIT    = 2;
    localparam int T_OPEN_P   = 3;
    localparam int T_UNLOCKED = 4;
    localparam int T_LOCK_P   = 5;
    localparam int T_BAD      = 6;
    localparam int T_LOCKOUT  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnten = 1'b1, up = 1'b1, dirch = 1'b0, doorCls = 1'b0;
    logic lock = 1'b1, open = 1'b1, eq = 1'b0;
    logic countEn, actuateLock, openCls, blank, clrCount, alarm;
    logic [1:0] sel;
    logic [1:0] fail_cnt;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    string       name_q[$];

    combo_lock_fsm #(
        .DIGITS(3), .SEL_W(2), .MAX_FAIL(3), .FAIL_W(2),
        .LOCKOUT_CYC(20), .CNT_W(16), .RELOCK_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .cnten(cnten), .up(up), .dirch(dirch),
        .doorCls(doorCls), .lock(lock), .open(open), .eq(eq),
        .countEn(countEn), .actuateLock(actuateLock), .openCls(openCls),
        .sel(sel), .blank(blank), .clrCount(clrCount), .alarm(alarm),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {countEn, actuateLock, openCls, sel, blank, clrCount, alarm, fail_cnt};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected output vector when the decoded state is st.
    function automatic logic [10:0] dec(input int st, input int ix, input int fc, input logic dc);
        logic ce = 1'b0, act = 1'b0, oc = 1'b0, bl = 1'b0, cc = 1'b1, al = 1'b0;
        logic [1:0] s = 2'd0;
        case (st)
            T_LOCKED:   begin ce = 1'b1; bl = 1'b1; cc = 1'b0; end
            T_DIGIT:    s = ix[1:0];
            T_OPEN_P:   begin oc = 1'b1; act = 1'b1; end
            T_UNLOCKED: begin bl = 1'b1; cc = 1'b0; end
            T_LOCK_P:   act = !dc;
            T_LOCKOUT:  begin bl = 1'b1; cc = 1'b0; al = 1'b1; end
            default:    ;
        endcase
        return {ce, act, oc, s, bl, cc, al, fc[1:0]};
    endfunction

    task automatic tick(input string nm, input int st, input int ix, input int fc);
        exp_q.push_back(dec(st, ix, fc, doorCls));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        obs_q.push_back(outs);
    endtask

    task automatic fail_attempt(input int kind, input int fc_before);
        open = 1'b0; tick("fail_open", T_LOCKED, 0, fc_before); open = 1'b1;
        cnten = 1'b0; up = 1'b0; tick("fail_start", T_START, 0, fc_before); cnten = 1'b1; up = 1'b1;
        if (kind == 1) begin
            dirch = 1'b1; eq = 1'b0; tick("fail_d0_dirch", T_DIGIT, 0, fc_before);
        end else begin
            dirch = 1'b1; eq = 1'b1;
            tick("fail_adv0", T_DIGIT, 0, fc_before);
            tick("fail_adv1", T_DIGIT, 1, fc_before);
            if (kind == 2) begin
                dirch = 1'b0; open = 1'b0; eq = 1'b0; tick("fail_last_open", T_DIGIT, 2, fc_before);
            end else begin
                dirch = 1'b1; eq = 1'b0; tick("fail_last_dirch", T_DIGIT, 2, fc_before);
            end
        end
        dirch = 1'b0; eq = 1'b0; open = 1'b1;
        tick("fail_bad", T_BAD, 0, (fc_before < 3) ? fc_before + 1 : 3);
    endtask

    task automatic test_reset;
        logic [10:0] e;
        logic [10:0] o;
        string n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== dec(T_LOCKED, 0, 0, doorCls)) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, dec(T_LOCKED, 0, 0, doorCls));
        end
        @(negedge clk) rst = 1'b0;
        tick("idle_locked", T_LOCKED, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_open;
        logic [10:0] e;
        logic [10:0] o;
        string n;
        open = 1'b0; tick("open_press", T_LOCKED, 0, 0); open = 1'b1;
        cnten = 1'b0; up = 1'b0; tick("start", T_START, 0, 0); cnten = 1'b1; up = 1'b1;
        tick("digit0", T_DIGIT, 0, 0);
        dirch = 1'b1; eq = 1'b1; tick("d0_match", T_DIGIT, 0, 0);
        dirch = 1'b0; eq = 1'b0; open = 1'b0; tick("d1_open_ignored", T_DIGIT, 1, 0); open = 1'b1;
        dirch = 1'b1; eq = 1'b1; tick("d1_match", T_DIGIT, 1, 0);
        dirch = 1'b0; eq = 1'b0; tick("digit2", T_DIGIT, 2, 0);
        open = 1'b0; eq = 1'b1; tick("d2_open", T_DIGIT, 2, 0);
        open = 1'b1; eq = 1'b0; tick("open_pulse", T_OPEN_P, 0, 0);
        tick("unlocked", T_UNLOCKED, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_lock;
        logic [10:0] e;
        logic [10:0] o;
        string n;
        doorCls = 1'b1; lock = 1'b0;
        tick("lock_door_open_a", T_UNLOCKED, 0, 0);
        tick("lock_door_open_b", T_UNLOCKED, 0, 0);
        doorCls = 1'b0; tick("lock_press", T_UNLOCKED, 0, 0);
        lock = 1'b1; tick("lock_pulse", T_LOCK_P, 0, 0);
        tick("relocked", T_LOCKED, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_lockout;
        logic [10:0] e;
        logic [10:0] o;
        string n;
        for (int k = 1; k <= 3; k++) fail_attempt(k, k - 1);
        for (int i = 0; i < 20; i++) begin
            open = (i % 3 == 0) ? 1'b0 : 1'b1;
            tick("lockout", T_LOCKOUT, 0, (i == 19) ? 0 : 3);
        end
        open = 1'b1;
        tick("post_lockout_a", T_LOCKED, 0, 0);
        tick("post_lockout_b", T_LOCKED, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_priority;
        logic [10:0] e;
        logic [10:0] o;
        string n;
        fail_attempt(1, 0);
        open = 1'b0; tick("prio_open", T_LOCKED, 0, 1); open = 1'b1;
        cnten = 1'b0; up = 1'b0; tick("prio_start", T_START, 0, 1); cnten = 1'b1; up = 1'b1;
        dirch = 1'b1; eq = 1'b1;
        tick("prio_adv0", T_DIGIT, 0, 1);
        tick("prio_adv1", T_DIGIT, 1, 1);
        open = 1'b0; tick("open_beats_dirch", T_DIGIT, 2, 1);
        open = 1'b1; dirch = 1'b0; eq = 1'b0;
        tick("prio_open_pulse", T_OPEN_P, 0, 0);
        lock = 1'b0; tick("prio_unlocked", T_UNLOCKED, 0, 0);
        lock = 1'b1; tick("prio_lock_pulse", T_LOCK_P, 0, 0);
        tick("prio_locked", T_LOCKED, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
    endtask

`ifdef AUTO_RELOCK_EN
    task automatic test_auto_relock;
        logic [10:0] e;
        logic [10:0] o;
        string n;
        open = 1'b0; tick("ar_open", T_LOCKED, 0, 0); open = 1'b1;
        cnten = 1'b0; up = 1'b0; tick("ar_start", T_START, 0, 0); cnten = 1'b1; up = 1'b1;
        dirch = 1'b1; eq = 1'b1;
        tick("ar_adv0", T_DIGIT, 0, 0);
        tick("ar_adv1", T_DIGIT, 1, 0);
        dirch = 1'b0; open = 1'b0; tick("ar_d2_open", T_DIGIT, 2, 0);
        open = 1'b1; eq = 1'b0; tick("ar_open_pulse", T_OPEN_P, 0, 0);
        doorCls = 1'b0; lock = 1'b1;
        repeat (5) tick("ar_closed_first", T_UNLOCKED, 0, 0);
        doorCls = 1'b1; tick("ar_reopen", T_UNLOCKED, 0, 0);
        doorCls = 1'b0;
        repeat (8) tick("ar_closed_count", T_UNLOCKED, 0, 0);
        tick("ar_lock_pulse", T_LOCK_P, 0, 0);
        tick("ar_locked", T_LOCKED, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
    endtask
`endif

    task automatic test_reset_in_lockout;
        logic [10:0] e;
        logic [10:0] o;
        string n;
        for (int k = 1; k <= 3; k++) fail_attempt(1, k - 1);
        repeat (5) tick("ril_lockout", T_LOCKOUT, 0, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outs !== dec(T_LOCKED, 0, 0, doorCls)) begin
            errors++;
            $display("FAIL reset_in_lockout: got %b expected %b", outs, dec(T_LOCKED, 0, 0, doorCls));
        end
        @(negedge clk) rst = 1'b0;
        open = 1'b0; tick("after_reset_open", T_LOCKED, 0, 0); open = 1'b1;
        tick("after_reset_start", T_START, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, o, e); end
        end
    endtask

    initial begin
        test_reset;
        test_open;
        test_lock;
        test_lockout;
        test_priority;
`ifdef AUTO_RELOCK_EN
        test_auto_relock;
`endif
        test_reset_in_lockout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
